// File: rtl/sm_serial_adder.sv
// Sign-magnitude serial adder/subtractor: SLICE bits per cycle, LSB first, N = WIDTH/SLICE cycles per op.
// Optional macro SM_ADDER_SAT_EN: saturate the magnitude to all ones on overflow instead of wrapping.
module sm_serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s_sign,
  output logic [WIDTH-1:0] s_mag,
  output logic             overflow
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_s_sign;
  logic [WIDTH-1:0]   r_s_mag;
  logic               r_overflow;

  logic [WIDTH-1:0]   r_big;
  logic [WIDTH-1:0]   r_small;
  logic               r_sub;
  logic               r_rsign;
  logic [WIDTH-1:0]   r_sum;

  logic               w_eb;
  logic               w_eff_sub;
  logic               w_swap;
  logic               w_accept;
  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_b_sl;
  logic [SLICE-1:0]   w_sum_sl;
  logic               w_cout;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_fin;

  assign w_eb      = b_sign ^ op_sub;
  assign w_eff_sub = a_sign ^ w_eb;
  // Subtraction always runs larger minus smaller; a tie keeps A as the minuend.
  assign w_swap    = w_eff_sub && (a_mag < b_mag);
  assign w_accept  = (r_state == IDLE) && in_valid;

  // Select the current slice of both operands.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_a_sl = r_big[k*SLICE +: SLICE];
        w_b_sl = r_small[k*SLICE +: SLICE];
      end
    end
  end

  // Ripple full-adder slice; subtrahend inverted, carry seeded with 1 at accept.
  always_comb begin
    logic c;
    logic bb;
    w_sum_sl = '0;
    c        = r_carry;
    for (int i = 0; i < SLICE; i++) begin
      bb          = w_b_sl[i] ^ r_sub;
      w_sum_sl[i] = w_a_sl[i] ^ bb ^ c;
      c           = (w_a_sl[i] & bb) | (c & (w_a_sl[i] ^ bb));
    end
    w_cout = c;
  end

  always_comb begin
    w_res = r_sum;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_res[k*SLICE +: SLICE] = w_sum_sl;
      end
    end
  end

  assign w_ovf = ~r_sub & w_cout;

`ifdef SM_ADDER_SAT_EN
  assign w_fin = w_ovf ? {WIDTH{1'b1}} : w_res;
`else
  assign w_fin = w_res;
`endif

  // Operand and partial-sum storage; only meaningful between accept and DONE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sub   <= w_eff_sub;
      r_big   <= w_swap ? b_mag : a_mag;
      r_small <= w_swap ? a_mag : b_mag;
      r_rsign <= w_swap ? w_eb  : a_sign;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_s_sign    <= 1'b0;
      r_s_mag     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
            r_carry    <= w_eff_sub;
          end
        end
        RUN: begin
          if (r_cnt == CNT_W'(N-1)) begin
            r_state     <= DONE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b1;
            r_s_mag     <= w_fin;
            r_s_sign    <= r_rsign & (|w_fin);
            r_overflow  <= w_ovf;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_cout;
          end
        end
        DONE: begin
          // Returning to IDLE costs one bubble: no accept on this edge.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s_sign    = r_s_sign;
  assign s_mag     = r_s_mag;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sm_serial_adder.sv
// Bench for sm_serial_adder: 8-bit/1-slice and 16-bit/4-slice instances, vector table, random ops vs arithmetic model.
module tb_sm_serial_adder;

`ifdef SM_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic       in_valid8, in_ready8, a_sign8, b_sign8, op_sub8, out_valid8, out_ready8, s_sign8, overflow8;
  logic [7:0] a_mag8, b_mag8, s_mag8;
  logic        in_valid16, in_ready16, a_sign16, b_sign16, op_sub16, out_valid16, out_ready16, s_sign16, overflow16;
  logic [15:0] a_mag16, b_mag16, s_mag16;

  int checks   = 0;
  int failures = 0;

  sm_serial_adder #(.WIDTH(8), .SLICE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_sign(a_sign8), .b_sign(b_sign8), .a_mag(a_mag8), .b_mag(b_mag8), .op_sub(op_sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .s_sign(s_sign8), .s_mag(s_mag8), .overflow(overflow8)
  );

  sm_serial_adder #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a_sign(a_sign16), .b_sign(b_sign16), .a_mag(a_mag16), .b_mag(b_mag16), .op_sub(op_sub16),
    .out_valid(out_valid16), .out_ready(out_ready16), .s_sign(s_sign16), .s_mag(s_mag16), .overflow(overflow16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit          w16;
    bit          as;
    int unsigned am;
    bit          bs;
    int unsigned bm;
    bit          sub;
    int          hold;
    bit          es;
    int unsigned em;
    bit          eo;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit w16, input bit v, input bit as, input int unsigned am,
                       input bit bs, input int unsigned bm, input bit sub);
    if (w16) begin
      in_valid16 = v; a_sign16 = as; a_mag16 = am[15:0]; b_sign16 = bs; b_mag16 = bm[15:0]; op_sub16 = sub;
    end else begin
      in_valid8 = v; a_sign8 = as; a_mag8 = am[7:0]; b_sign8 = bs; b_mag8 = bm[7:0]; op_sub8 = sub;
    end
  endtask

  function automatic bit rd_ov(input bit w16);
    return w16 ? out_valid16 : out_valid8;
  endfunction
  function automatic bit rd_ir(input bit w16);
    return w16 ? in_ready16 : in_ready8;
  endfunction
  function automatic bit rd_sign(input bit w16);
    return w16 ? s_sign16 : s_sign8;
  endfunction
  function automatic bit rd_ovf(input bit w16);
    return w16 ? overflow16 : overflow8;
  endfunction
  function automatic int unsigned rd_mag(input bit w16);
    return w16 ? 32'(s_mag16) : 32'(s_mag8);
  endfunction

  // Reference: signed integer arithmetic, then convert back to sign/magnitude.
  task automatic model(input bit w16, input bit as, input int unsigned am, input bit bs,
                       input int unsigned bm, input bit sub,
                       output bit es, output int unsigned em, output bit eo);
    longint mx, va, vb, s, ab;
    mx = (64'sd1 <<< (w16 ? 16 : 8)) - 1;
    va = as ? -longint'(am) : longint'(am);
    vb = bs ? -longint'(bm) : longint'(bm);
    s  = sub ? va - vb : va + vb;
    ab = (s < 0) ? -s : s;
    eo = (ab > mx);
    if (eo) em = SAT ? int'(mx) : int'(ab % (mx + 1));
    else    em = int'(ab);
    es = (em != 0) && (s < 0);
  endtask

  task automatic do_op(input bit w16, input bit as, input int unsigned am, input bit bs,
                       input int unsigned bm, input bit sub, input int hold,
                       input bit es, input int unsigned em, input bit eo, input string nm);
    int lat;
    bit got;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, rd_ir(w16), 1);
    drive(w16, 1'b1, as, am, bs, bm, sub);
    @(posedge clk);
    #1 drive(w16, 1'b1, 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rd_ov(w16)) got = 1'b1;
    end
    chk({nm, "_latency"}, lat, w16 ? 4 : 8);
    chk({nm, "_s_sign"}, rd_sign(w16), es);
    chk({nm, "_s_mag"}, rd_mag(w16), em);
    chk({nm, "_overflow"}, rd_ovf(w16), eo);
    chk({nm, "_in_ready_done"}, rd_ir(w16), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, rd_ov(w16), 1);
      chk({nm, "_hold_mag"}, rd_mag(w16), em);
      chk({nm, "_hold_sign"}, rd_sign(w16), es);
      chk({nm, "_hold_ovf"}, rd_ovf(w16), eo);
      chk({nm, "_hold_in_ready"}, rd_ir(w16), 0);
    end
    if (w16) out_ready16 = 1'b1; else out_ready8 = 1'b1;
    @(negedge clk);
    chk({nm, "_exit_valid"}, rd_ov(w16), 0);
    chk({nm, "_exit_in_ready"}, rd_ir(w16), 1);
    chk({nm, "_kept_mag"}, rd_mag(w16), em);
    if (w16) out_ready16 = 1'b0; else out_ready8 = 1'b0;
    drive(w16, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  function automatic int unsigned pick(input bit w16);
    int unsigned mx;
    mx = w16 ? 65535 : 255;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return mx;
      2:       return 1;
      default: return $urandom_range(0, mx);
    endcase
  endfunction

  initial begin
    bit          es, eo, w16, as, bs, sub;
    int unsigned em, am, bm;
    int          seen;

    rst_n = 1'b0;
    out_ready8 = 1'b0;
    out_ready16 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

    tbl[0]  = '{0, 0, 5,     0, 3,    0, 0, 0, 8,                     0};
    tbl[1]  = '{0, 0, 3,     0, 5,    1, 0, 1, 2,                     0};
    tbl[2]  = '{0, 1, 7,     0, 7,    0, 0, 0, 0,                     0};
    tbl[3]  = '{0, 0, 200,   0, 100,  0, 0, 0, SAT ? 255 : 44,        1};
    tbl[4]  = '{0, 0, 10,    0, 4,    0, 5, 0, 14,                    0};
    tbl[5]  = '{0, 1, 128,   1, 128,  0, 0, SAT, SAT ? 255 : 0,       1};
    tbl[6]  = '{0, 0, 255,   1, 255,  1, 0, 0, SAT ? 255 : 254,       1};
    tbl[7]  = '{0, 1, 20,    1, 50,   1, 1, 0, 30,                    0};
    tbl[8]  = '{0, 1, 9,     0, 4,    0, 0, 1, 5,                     0};
    tbl[9]  = '{0, 0, 0,     0, 0,    1, 0, 0, 0,                     0};
    tbl[10] = '{1, 1, 1000,  1, 2000, 0, 0, 1, 3000,                  0};
    tbl[11] = '{1, 0, 65535, 0, 1,    0, 0, 0, SAT ? 65535 : 0,       1};
    tbl[12] = '{1, 0, 40000, 1, 1234, 1, 2, 0, 41234,                 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_in_ready8", in_ready8, 1);
    chk("rst_s_mag8", s_mag8, 0);
    chk("rst_s_sign8", s_sign8, 0);
    chk("rst_overflow8", overflow8, 0);
    chk("rst_out_valid16", out_valid16, 0);
    chk("rst_in_ready16", in_ready16, 1);

    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].w16, tbl[i].as, tbl[i].am, tbl[i].bs, tbl[i].bm, tbl[i].sub, tbl[i].hold,
            tbl[i].es, tbl[i].em, tbl[i].eo, $sformatf("vec%0d", i));
    end

    // Reset in the middle of RUN.
    do_op(1'b0, 1'b1, 5, 1'b1, 3, 1'b0, 0, 1'b1, 8, 1'b0, "pre_reset");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 9, 1'b0, 6, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_s_mag", s_mag8, 0);
    chk("abort_s_sign", s_sign8, 0);
    chk("abort_overflow", overflow8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid8) seen++;
    end
    chk("abort_no_result", seen, 0);
    chk("abort_in_ready", in_ready8, 1);
    do_op(1'b0, 1'b0, 9, 1'b0, 6, 1'b0, 0, 1'b0, 15, 1'b0, "post_reset");

    for (int i = 0; i < 40; i++) begin
      w16 = (i % 4 == 3);
      as  = 1'($urandom);
      bs  = 1'($urandom);
      sub = 1'($urandom);
      am  = pick(w16);
      bm  = pick(w16);
      model(w16, as, am, bs, bm, sub, es, em, eo);
      do_op(w16, as, am, bs, bm, sub, int'($urandom_range(0, 2)), es, em, eo, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
